mem_stage_lsu: RTL
==================

Name: mem_stage_lsu

Overview:
- Memory-access pipeline stage; consumes the load/store control produced by instruction decode (mem_r_ena, mem_w_ena, byte_enable, mem_ext_un) once EX has produced the effective address.
- Turns each access into one 64-bit, doubleword-aligned bus transaction, then lane-shifts and sign/zero-extends load data for writeback.
- Non-memory instructions pass their ALU result through with one cycle of latency.
- Valid/ready handshake on the upstream, bus and writeback sides.

Parameters:
- XLEN, 64, data/address width (REG_BUS).
- RESET_PC_UNUSED, 0, reserved; must stay 0.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  EX result valid.
- in_ready  out  1  stage can accept.
- mem_r_ena  in  1  load.
- mem_w_ena  in  1  store.
- byte_enable  in  8  size mask: 0x01, 0x03, 0x0F or 0xFF.
- mem_ext_un  in  1  zero-extend load.
- alu_result  in  XLEN  effective address, or the result for non-memory ops.
- store_data  in  XLEN  rs2 value.
- rd_w_ena  in  1  destination write enable.
- rd_w_addr  in  5  destination register.
- bus_req_valid  out  1  bus request.
- bus_req_ready  in  1  bus accepts request.
- bus_req_we  out  1  1 = write.
- bus_req_addr  out  XLEN  {addr[63:3],3'b0}.
- bus_req_wdata  out  XLEN  lane-shifted store data.
- bus_req_wstrb  out  8  lane-shifted byte strobe.
- bus_resp_valid  in  1  read data or write acknowledge.
- bus_resp_rdata  in  XLEN  read doubleword.
- out_valid  out  1  writeback entry valid.
- out_ready  in  1  WB accepts.
- wb_data  out  XLEN  result.
- wb_rd_ena  out  1  register write enable.
- wb_rd_addr  out  5  destination register.
- mem_err  out  1  misaligned access or illegal size; no bus access was made.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - bus_req_valid, out_valid, wb_rd_ena and mem_err are 0; wb_data and wb_rd_addr are 0.
  - in_ready is 1 (in_ready = state==IDLE).
- Reset mid-transaction abandons the access; bus_req_valid drops immediately. The bus responder shares this reset.
- Access decode:
  - off = alu_result[2:0].
  - err = mem op AND (byte_enable not one of the 4 legal masks, OR (off & (popcount(byte_enable)-1)) != 0).
- FSM states: IDLE, REQ, RESP, OUT.
- IDLE:
  - On in_valid && in_ready, all inputs are registered.
  - Non-memory op: wb_data = alu_result; go to OUT.
  - err: mem_err = 1, wb_rd_ena = 0; go to OUT.
  - Otherwise: go to REQ.
- REQ:
  - bus_req_valid = 1.
  - bus_req_we = stored mem_w_ena.
  - bus_req_wstrb = byte_enable << off.
  - bus_req_wdata = store_data << (8*off).
  - All request fields are held stable until bus_req_ready; then go to RESP.
  - bus_resp_valid is ignored in REQ; the responder answers no earlier than the cycle after acceptance.
- RESP:
  - Wait for bus_resp_valid.
  - Load: wb_data = extend((bus_resp_rdata >> 8*off) masked to size). Sign-extension comes from the top byte of the access unless mem_ext_un; ld takes the doubleword unmodified.
  - Store: wb_rd_ena = 0 and rdata is ignored.
  - Then go to OUT.
- OUT:
  - out_valid = 1; wb_* are held stable until out_ready, then go to IDLE.
  - A new input is not accepted in the same cycle (in_ready = 0 in OUT).
- Latency, accept at cycle T with zero-wait bus and WB:
  - Non-memory op or err: out_valid at T+1.
  - Load/store: bus_req_valid at T+1, resp at T+2, out_valid at T+3.
- Both mem_r_ena and mem_w_ena set is treated as a store.
- mem_err is cleared on the next accept.

Test Plan:
- Non-memory op: alu_result=0x1234, rd=5, out_ready=1 -> out_valid at T+1, wb_data=0x1234, wb_rd_ena=1, no bus_req_valid.
- lb addr 0x1003, rdata=0x00000000_80000000 -> bus_req_addr=0x1000, wb_data=0xFFFFFFFF_FFFFFF80. Same access with lbu -> wb_data=0x80.
- sh addr 0x2006, store_data=0xBEEF, bus_req_ready delayed 3 cycles -> wstrb=0xC0, wdata=0xBEEF<<48, request fields stable while waiting, wb_rd_ena=0.
- lw addr 0x3002 -> mem_err=1, out_valid at T+1, bus_req_valid never asserted, wb_rd_ena=0.
- out_ready held 0 for 4 cycles after a ld of 0x11223344_55667788 -> wb_data stable, in_ready=0, single transfer on release.
- rst_n pulsed low while in RESP -> bus_req_valid=0, out_valid=0, in_ready=1 immediately; next accepted op completes normally.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// Memory-access stage: one aligned 64-bit bus transaction per load/store, lane-shift + extend for writeback.
// Latency: non-memory/error 1 cycle to out_valid; load/store 3 cycles with zero-wait bus and writeback.
// Backpressure: in_ready only in IDLE; bus request and wb outputs held stable until bus_req_ready / out_ready.
module mem_stage_lsu #(
  parameter int XLEN            = 64,
  parameter int RESET_PC_UNUSED = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            mem_r_ena,
  input  logic            mem_w_ena,
  input  logic [7:0]      byte_enable,
  input  logic            mem_ext_un,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] store_data,
  input  logic            rd_w_ena,
  input  logic [4:0]      rd_w_addr,
  output logic            bus_req_valid,
  input  logic            bus_req_ready,
  output logic            bus_req_we,
  output logic [XLEN-1:0] bus_req_addr,
  output logic [XLEN-1:0] bus_req_wdata,
  output logic [7:0]      bus_req_wstrb,
  input  logic            bus_resp_valid,
  input  logic [XLEN-1:0] bus_resp_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_rd_ena,
  output logic [4:0]      wb_rd_addr,
  output logic            mem_err
);

  // Reserved parameter; any non-zero value is meaningless for this stage.
  if (RESET_PC_UNUSED != 0) begin : g_reset_pc_must_be_zero
  end

  typedef enum logic [1:0] {IDLE, REQ, RESP, OUT} state_t;

  state_t          state_q;
  logic [2:0]      off_q;
  logic [7:0]      be_q;
  logic            ext_un_q;
  logic            store_q;
  logic            rd_ena_q;

  logic [2:0]      off;
  logic            is_mem;
  logic            legal_size;
  logic [2:0]      size_mask;
  logic            err;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_val;

  assign in_ready = (state_q == IDLE);
  assign off      = alu_result[2:0];
  assign is_mem   = mem_r_ena | mem_w_ena;

  // Size legality and the low address bits that must be zero for natural alignment.
  always_comb begin
    legal_size = 1'b1;
    size_mask  = 3'd0;
    case (byte_enable)
      8'h01:   size_mask = 3'd0;
      8'h03:   size_mask = 3'd1;
      8'h0F:   size_mask = 3'd3;
      8'hFF:   size_mask = 3'd7;
      default: legal_size = 1'b0;
    endcase
    err = is_mem & (~legal_size | ((off & size_mask) != 3'd0));
  end

  // Bring the addressed lane down to bit 0 and extend from the access's top byte.
  always_comb begin
    shifted  = bus_resp_rdata >> {off_q, 3'b000};
    load_val = shifted;
    case (be_q)
      8'h01:   load_val = {{(XLEN-8){shifted[7] & ~ext_un_q}}, shifted[7:0]};
      8'h03:   load_val = {{(XLEN-16){shifted[15] & ~ext_un_q}}, shifted[15:0]};
      8'h0F:   load_val = {{(XLEN-32){shifted[31] & ~ext_un_q}}, shifted[31:0]};
      default: load_val = shifted;
    endcase
  end

  // Access FSM with registered bus and writeback outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      off_q         <= 3'd0;
      be_q          <= 8'd0;
      ext_un_q      <= 1'b0;
      store_q       <= 1'b0;
      rd_ena_q      <= 1'b0;
      bus_req_valid <= 1'b0;
      bus_req_we    <= 1'b0;
      bus_req_addr  <= '0;
      bus_req_wdata <= '0;
      bus_req_wstrb <= 8'd0;
      out_valid     <= 1'b0;
      wb_data       <= '0;
      wb_rd_ena     <= 1'b0;
      wb_rd_addr    <= 5'd0;
      mem_err       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            off_q      <= off;
            be_q       <= byte_enable;
            ext_un_q   <= mem_ext_un;
            store_q    <= mem_w_ena;
            rd_ena_q   <= rd_w_ena;
            wb_rd_addr <= rd_w_addr;
            mem_err    <= err;
            if (!is_mem) begin
              wb_data   <= alu_result;
              wb_rd_ena <= rd_w_ena;
              out_valid <= 1'b1;
              state_q   <= OUT;
            end else if (err) begin
              wb_data   <= '0;
              wb_rd_ena <= 1'b0;
              out_valid <= 1'b1;
              state_q   <= OUT;
            end else begin
              bus_req_valid <= 1'b1;
              bus_req_we    <= mem_w_ena;
              bus_req_addr  <= {alu_result[XLEN-1:3], 3'b000};
              bus_req_wdata <= store_data << {off, 3'b000};
              bus_req_wstrb <= byte_enable << off;
              state_q       <= REQ;
            end
          end
        end
        REQ: begin
          if (bus_req_ready) begin
            bus_req_valid <= 1'b0;
            state_q       <= RESP;
          end
        end
        RESP: begin
          if (bus_resp_valid) begin
            if (store_q) begin
              wb_data   <= '0;
              wb_rd_ena <= 1'b0;
            end else begin
              wb_data   <= load_val;
              wb_rd_ena <= rd_ena_q;
            end
            out_valid <= 1'b1;
            state_q   <= OUT;
          end
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
